// File: rtl/framebuffer_dbuf.sv
// Double-buffered pixel RAM: writer fills the back bank, scanner reads the front bank,
// banks swap only on a scanner frame boundary; a clear engine zeroes the back bank.
module framebuffer_dbuf #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  swap_req,
    input  logic                  frame_end,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  swap_pending,
    output logic                  front_bank
);

    localparam int MEM_DEPTH = 2 ** (ADDR_WIDTH + 1);
    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_CLEAR = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  state_r;
    logic [ADDR_WIDTH-1:0] clearAddr_r;
    logic                  frontBank_r;
    logic                  swapPending_r;
    logic [DATA_WIDTH-1:0] rdData_r;
    logic                  rdValid_r;

    logic                  memWe_s;
    logic [ADDR_WIDTH:0]   memWaddr_s;
    logic [DATA_WIDTH-1:0] memWdata_s;
    logic                  swapNow_s;

    // A swap is refused while clearing so the whole clear lands in one bank.
    assign swapNow_s = frame_end & swapPending_r & (state_r == STATE_IDLE);

    // Single write port shared by the clear engine and the writer; reset blocks both.
    always_comb begin
        memWe_s    = 1'b0;
        memWaddr_s = {~frontBank_r, wr_addr};
        memWdata_s = wr_data;
        if (reset) begin
            memWe_s = 1'b0;
        end else if (state_r == STATE_CLEAR) begin
            memWe_s    = 1'b1;
            memWaddr_s = {~frontBank_r, clearAddr_r};
            memWdata_s = {DATA_WIDTH{1'b0}};
        end else if (wr_en) begin
            memWe_s = 1'b1;
        end else begin
            memWe_s = 1'b0;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (memWe_s) begin
            mem[memWaddr_s] <= memWdata_s;
        end
    end

    // Clear engine FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= STATE_IDLE;
            clearAddr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                STATE_IDLE: begin
                    if (clear_req) begin
                        state_r     <= STATE_CLEAR;
                        clearAddr_r <= {ADDR_WIDTH{1'b0}};
                    end
                end
                STATE_CLEAR: begin
                    clearAddr_r <= clearAddr_r + ADDR_ONE;
                    if (clearAddr_r == LAST_ADDR) begin
                        state_r <= STATE_IDLE;
                    end
                end
                default: begin
                    state_r     <= STATE_IDLE;
                    clearAddr_r <= {ADDR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Swap handshake: a qualifying frame_end wins over a simultaneous swap_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            frontBank_r   <= 1'b0;
            swapPending_r <= 1'b0;
        end else if (swapNow_s) begin
            frontBank_r   <= ~frontBank_r;
            swapPending_r <= 1'b0;
        end else if (swap_req) begin
            swapPending_r <= 1'b1;
        end
    end

    // Registered read from the front bank as it stands in the rd_en cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdData_r  <= {DATA_WIDTH{1'b0}};
            rdValid_r <= 1'b0;
        end else if (rd_en) begin
            rdData_r  <= mem[{frontBank_r, rd_addr}];
            rdValid_r <= 1'b1;
        end else begin
            rdValid_r <= 1'b0;
        end
    end

    assign rd_data      = rdData_r;
    assign rd_valid     = rdValid_r;
    assign busy         = (state_r == STATE_CLEAR);
    assign swap_pending = swapPending_r;
    assign front_bank   = frontBank_r;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Bench for framebuffer_dbuf: default instance checked against a bank/array model,
// plus a small DATA_WIDTH=8 / ADDR_WIDTH=4 instance checked with directed values.
module tb_framebuffer_dbuf;

    localparam int DEPTH_A = 2048;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        wrEn = 1'b0, rdEn = 1'b0, swapReq = 1'b0, frameEnd = 1'b0, clearReq = 1'b0;
    logic [10:0] wrAddr = 11'd0, rdAddr = 11'd0;
    logic [1:0]  wrData = 2'd0;
    logic [1:0]  rdData;
    logic        rdValid, busy, swapPending, frontBank;

    logic        bWrEn = 1'b0, bRdEn = 1'b0, bSwapReq = 1'b0, bFrameEnd = 1'b0, bClearReq = 1'b0;
    logic [3:0]  bWrAddr = 4'd0, bRdAddr = 4'd0;
    logic [7:0]  bWrData = 8'd0;
    logic [7:0]  bRdData;
    logic        bRdValid, bBusy, bSwapPending, bFrontBank;

    int passCount = 0;
    int checkCount = 0;

    // Reference model state
    int mMem [2][DEPTH_A];
    bit mKnown [2][DEPTH_A];
    int mFront = 0;
    bit mPending = 1'b0;
    int mClearLeft = 0;
    int mRdData = 0;
    bit mRdKnown = 1'b1;
    bit mRdValid = 1'b0;

    always #5 clk = ~clk;

    framebuffer_dbuf dutA (
        .clk(clk), .reset(reset),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData), .rd_valid(rdValid),
        .swap_req(swapReq), .frame_end(frameEnd), .clear_req(clearReq),
        .busy(busy), .swap_pending(swapPending), .front_bank(frontBank)
    );

    framebuffer_dbuf #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dutB (
        .clk(clk), .reset(reset),
        .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData),
        .rd_en(bRdEn), .rd_addr(bRdAddr), .rd_data(bRdData), .rd_valid(bRdValid),
        .swap_req(bSwapReq), .frame_end(bFrameEnd), .clear_req(bClearReq),
        .busy(bBusy), .swap_pending(bSwapPending), .front_bank(bFrontBank)
    );

    // Advance one clock on instance A, updating the model from the applied inputs.
    task automatic tickA();
        bit busyNow;
        int back;
        int idx;
        busyNow = (mClearLeft != 0);
        back = 1 - mFront;
        if (reset) begin
            mFront = 0; mPending = 1'b0; mClearLeft = 0;
            mRdData = 0; mRdKnown = 1'b1; mRdValid = 1'b0;
        end else begin
            if (rdEn) begin
                mRdValid = 1'b1;
                mRdKnown = mKnown[mFront][rdAddr];
                mRdData  = mMem[mFront][rdAddr];
            end else begin
                mRdValid = 1'b0;
            end
            if (busyNow) begin
                idx = DEPTH_A - mClearLeft;
                mMem[back][idx] = 0;
                mKnown[back][idx] = 1'b1;
                mClearLeft--;
            end else begin
                if (wrEn) begin
                    mMem[back][wrAddr] = int'(wrData);
                    mKnown[back][wrAddr] = 1'b1;
                end
                if (clearReq) mClearLeft = DEPTH_A;
            end
            if (frameEnd && mPending && !busyNow) begin
                mFront = 1 - mFront;
                mPending = 1'b0;
            end else if (swapReq) begin
                mPending = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleA();
        wrEn = 1'b0; rdEn = 1'b0; swapReq = 1'b0; frameEnd = 1'b0; clearReq = 1'b0;
    endtask

    task automatic pulseA(input bit doSwap, input bit doFrame, input bit doClear);
        idleA();
        swapReq = doSwap; frameEnd = doFrame; clearReq = doClear;
        tickA();
        idleA();
    endtask

    task automatic readA(input int addr);
        idleA();
        rdEn = 1'b1; rdAddr = addr[10:0];
        tickA();
        idleA();
    endtask

    task automatic writeA(input int addr, input int data);
        idleA();
        wrEn = 1'b1; wrAddr = addr[10:0]; wrData = data[1:0];
        tickA();
        idleA();
    endtask

    task automatic waitClearA(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 5000) begin
            tickA();
            cycles++;
        end
    endtask

    task automatic test_reset();
        idleA();
        reset = 1'b1;
        tickA(); tickA();
        reset = 1'b0;
        checkCount++; if (frontBank !== 1'b0) $display("FAIL reset_front got %0d exp 0", frontBank); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL reset_busy got %0d exp 0", busy); else passCount++;
        checkCount++; if (rdValid !== 1'b0) $display("FAIL reset_rd_valid got %0d exp 0", rdValid); else passCount++;
        checkCount++; if (swapPending !== 1'b0) $display("FAIL reset_pending got %0d exp 0", swapPending); else passCount++;
        checkCount++; if (rdData !== 2'd0) $display("FAIL reset_rd_data got %0d exp 0", rdData); else passCount++;
    endtask

    task automatic test_swap();
        int cyc;
        for (int k = 0; k < 2; k++) begin
            pulseA(1'b0, 1'b0, 1'b1);
            waitClearA(cyc);
            pulseA(1'b1, 1'b0, 1'b0);
            pulseA(1'b0, 1'b1, 1'b0);
        end
        checkCount++; if (frontBank !== 1'b0) $display("FAIL swap_setup_front got %0d exp 0", frontBank); else passCount++;
        writeA(5, 3);
        readA(5);
        checkCount++; if (rdData !== 2'd0 || rdValid !== 1'b1) $display("FAIL swap_read_old got %0d/%0d exp 0/1", rdData, rdValid); else passCount++;
        pulseA(1'b1, 1'b0, 1'b0);
        pulseA(1'b0, 1'b1, 1'b0);
        checkCount++; if (frontBank !== 1'b1) $display("FAIL swap_front got %0d exp 1", frontBank); else passCount++;
        readA(5);
        checkCount++; if (rdData !== 2'd3 || rdValid !== 1'b1) $display("FAIL swap_read_new got %0d/%0d exp 3/1", rdData, rdValid); else passCount++;
        tickA();
        checkCount++; if (rdValid !== 1'b0) $display("FAIL swap_valid_drop got %0d exp 0", rdValid); else passCount++;
    endtask

    task automatic test_pending();
        logic saved;
        saved = frontBank;
        pulseA(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) tickA();
        checkCount++; if (swapPending !== 1'b1) $display("FAIL pend_hold got %0d exp 1", swapPending); else passCount++;
        checkCount++; if (frontBank !== saved) $display("FAIL pend_front got %0d exp %0d", frontBank, saved); else passCount++;
        pulseA(1'b0, 1'b1, 1'b0);
        checkCount++; if (frontBank !== ~saved || swapPending !== 1'b0) $display("FAIL pend_swap got %0d/%0d exp %0d/0", frontBank, swapPending, ~saved); else passCount++;
        pulseA(1'b1, 1'b1, 1'b0);
        checkCount++; if (frontBank !== ~saved || swapPending !== 1'b1) $display("FAIL pend_same_cycle got %0d/%0d exp %0d/1", frontBank, swapPending, ~saved); else passCount++;
        pulseA(1'b0, 1'b1, 1'b0);
        checkCount++; if (frontBank !== saved || swapPending !== 1'b0) $display("FAIL pend_consume got %0d/%0d exp %0d/0", frontBank, swapPending, saved); else passCount++;
    endtask

    task automatic test_clear();
        int cnt;
        for (int a = 0; a < DEPTH_A; a++) writeA(a, 2);
        pulseA(1'b0, 1'b0, 1'b1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            wrEn = 1'b1; wrAddr = 11'($urandom_range(0, DEPTH_A - 1)); wrData = 2'd3;
            tickA();
            cnt++;
        end
        idleA();
        checkCount++; if (cnt != 2048) $display("FAIL clear_busy_len got %0d exp 2048", cnt); else passCount++;
        pulseA(1'b1, 1'b0, 1'b0);
        pulseA(1'b0, 1'b1, 1'b0);
        readA(0);
        checkCount++; if (rdData !== 2'd0) $display("FAIL clear_addr0 got %0d exp 0", rdData); else passCount++;
        readA(1023);
        checkCount++; if (rdData !== 2'd0) $display("FAIL clear_addr1023 got %0d exp 0", rdData); else passCount++;
        readA(2047);
        checkCount++; if (rdData !== 2'd0) $display("FAIL clear_addr2047 got %0d exp 0", rdData); else passCount++;
    endtask

    task automatic test_swap_blocked();
        logic saved;
        int cyc;
        saved = frontBank;
        pulseA(1'b0, 1'b0, 1'b1);
        pulseA(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 499; i++) tickA();
        pulseA(1'b0, 1'b1, 1'b0);
        checkCount++; if (frontBank !== saved || swapPending !== 1'b1) $display("FAIL blocked_swap got %0d/%0d exp %0d/1", frontBank, swapPending, saved); else passCount++;
        checkCount++; if (busy !== 1'b1) $display("FAIL blocked_busy got %0d exp 1", busy); else passCount++;
        waitClearA(cyc);
        checkCount++; if (busy !== 1'b0) $display("FAIL blocked_clear_end got %0d exp 0", busy); else passCount++;
        pulseA(1'b0, 1'b1, 1'b0);
        checkCount++; if (frontBank !== ~saved || swapPending !== 1'b0) $display("FAIL blocked_late_swap got %0d/%0d exp %0d/0", frontBank, swapPending, ~saved); else passCount++;
    endtask

    task automatic test_reset_mid_clear();
        if (frontBank !== 1'b1) begin
            pulseA(1'b1, 1'b0, 1'b0);
            pulseA(1'b0, 1'b1, 1'b0);
        end
        for (int a = 0; a <= 310; a++) writeA(a, 1);
        pulseA(1'b0, 1'b0, 1'b1);
        pulseA(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 300; i++) tickA();
        reset = 1'b1;
        tickA();
        reset = 1'b0;
        checkCount++; if (busy !== 1'b0 || swapPending !== 1'b0 || frontBank !== 1'b0) $display("FAIL midclr_state got %0d/%0d/%0d exp 0/0/0", busy, swapPending, frontBank); else passCount++;
        readA(0);
        checkCount++; if (rdData !== 2'd0) $display("FAIL midclr_addr0 got %0d exp 0", rdData); else passCount++;
        readA(299);
        checkCount++; if (rdData !== 2'd0) $display("FAIL midclr_addr299 got %0d exp 0", rdData); else passCount++;
        readA(300);
        checkCount++; if (rdData !== 2'd1) $display("FAIL midclr_addr300 got %0d exp 1", rdData); else passCount++;
        readA(310);
        checkCount++; if (rdData !== 2'd1) $display("FAIL midclr_addr310 got %0d exp 1", rdData); else passCount++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            wrEn     = ($urandom_range(0, 1) == 1);
            wrAddr   = 11'($urandom_range(0, DEPTH_A - 1));
            wrData   = 2'($urandom_range(0, 3));
            rdEn     = ($urandom_range(0, 1) == 1);
            rdAddr   = ($urandom_range(0, 3) == 0) ? wrAddr : 11'($urandom_range(0, DEPTH_A - 1));
            swapReq  = ($urandom_range(0, 19) == 0);
            frameEnd = ($urandom_range(0, 29) == 0);
            clearReq = ($urandom_range(0, 1499) == 0);
            tickA();
            checkCount++; if (rdValid !== mRdValid) $display("FAIL rnd_valid cyc %0d got %0d exp %0d", i, rdValid, mRdValid); else passCount++;
            if (mRdKnown) begin
                checkCount++; if (rdData !== 2'(mRdData)) $display("FAIL rnd_data cyc %0d got %0d exp %0d", i, rdData, mRdData); else passCount++;
            end
            checkCount++; if (frontBank !== 1'(mFront)) $display("FAIL rnd_front cyc %0d got %0d exp %0d", i, frontBank, mFront); else passCount++;
            checkCount++; if (swapPending !== mPending) $display("FAIL rnd_pending cyc %0d got %0d exp %0d", i, swapPending, mPending); else passCount++;
            checkCount++; if (busy !== (mClearLeft != 0)) $display("FAIL rnd_busy cyc %0d got %0d exp %0d", i, busy, (mClearLeft != 0)); else passCount++;
        end
        idleA();
    endtask

    task automatic tickB();
        @(posedge clk);
        #1;
        bWrEn = 1'b0; bRdEn = 1'b0; bSwapReq = 1'b0; bFrameEnd = 1'b0; bClearReq = 1'b0;
    endtask

    task automatic test_param();
        int cnt;
        reset = 1'b1;
        tickB();
        reset = 1'b0;
        bClearReq = 1'b1;
        tickB();
        cnt = 0;
        while (bBusy === 1'b1 && cnt < 100) begin
            tickB();
            cnt++;
        end
        checkCount++; if (cnt != 16) $display("FAIL param_clear_len got %0d exp 16", cnt); else passCount++;
        bWrEn = 1'b1; bWrAddr = 4'd0; bWrData = 8'h3C;
        tickB();
        bWrEn = 1'b1; bWrAddr = 4'd15; bWrData = 8'hA5;
        tickB();
        tickB();
        checkCount++; if (bBusy !== 1'b0) $display("FAIL param_busy_after got %0d exp 0", bBusy); else passCount++;
        bSwapReq = 1'b1;
        tickB();
        bFrameEnd = 1'b1;
        tickB();
        checkCount++; if (bFrontBank !== 1'b1) $display("FAIL param_front got %0d exp 1", bFrontBank); else passCount++;
        bRdEn = 1'b1; bRdAddr = 4'd15;
        tickB();
        checkCount++; if (bRdData !== 8'hA5 || bRdValid !== 1'b1) $display("FAIL param_addr15 got %0h/%0d exp a5/1", bRdData, bRdValid); else passCount++;
        bRdEn = 1'b1; bRdAddr = 4'd0;
        tickB();
        checkCount++; if (bRdData !== 8'h3C) $display("FAIL param_addr0 got %0h exp 3c", bRdData); else passCount++;
        bRdEn = 1'b1; bRdAddr = 4'd7;
        tickB();
        checkCount++; if (bRdData !== 8'h00) $display("FAIL param_addr7 got %0h exp 0", bRdData); else passCount++;
    endtask

    initial begin
        test_reset();
        test_swap();
        test_pending();
        test_clear();
        test_swap_blocked();
        test_reset_mid_clear();
        test_random();
        test_param();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/framebuffer_dbuf.md
# framebuffer_dbuf

Parametrised double-buffered pixel RAM for the LED panel datapath. It holds two banks of 2^ADDR_WIDTH words of DATA_WIDTH bits. The UART/command side writes the back bank while the row scanner reads the front bank. Banks swap only at a scanner frame boundary, so a frame is never displayed half-written. A built-in clear engine zeroes the back bank one word per cycle.

## Interface
Parameters:
- DATA_WIDTH, 2, bits per stored word (pixel/plane slice)
- ADDR_WIDTH, 11, address bits per bank; bank depth = 2^ADDR_WIDTH

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe, back bank
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe, front bank
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  high one cycle after an accepted rd_en
- swap_req  in  1  pulse: writer has finished a frame
- frame_end  in  1  pulse from scanner: last row of frame shown
- clear_req  in  1  pulse: zero the whole back bank
- busy  out  1  clear engine active
- swap_pending  out  1  swap requested, not yet performed
- front_bank  out  1  index of the bank currently being read

## Operation
- Storage is 2 × 2^ADDR_WIDTH × DATA_WIDTH.
  - Bank address = {bank, addr}.
  - The back bank is ~front_bank.
  - Contents are not reset and have no defined initial value.
- Write: if wr_en=1 and state is IDLE, store wr_data at {~front_bank, wr_addr}. wr_en is ignored in CLEAR.
- Read: if rd_en=1, rd_data <= mem[{front_bank, rd_addr}] and rd_valid <= 1. Otherwise rd_data holds and rd_valid <= 0.
- Swap handshake:
  - swap_req sets swap_pending. swap_req while swap_pending=1 has no further effect.
  - When frame_end=1, swap_pending=1 and busy=0: toggle front_bank and clear swap_pending in the same cycle.
  - frame_end with swap_pending=0 does nothing.
  - frame_end while busy=1 does nothing; the swap stays pending for a later frame_end.
  - swap_req and frame_end in the same cycle with swap_pending=0: swap_pending becomes 1 and no swap occurs that cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clear_req=1. clear_addr <= 0.
  - In CLEAR: write 0 to {~front_bank, clear_addr}, then clear_addr <= clear_addr+1 (ADDR_WIDTH wide).
  - CLEAR → IDLE in the cycle that writes clear_addr = 2^ADDR_WIDTH−1.
  - clear_req is ignored in CLEAR.
  - busy = (state == CLEAR).
  - front_bank cannot change during CLEAR, so the clear always targets one bank.
- Reset (any cycle, including mid-clear):
  - state=IDLE, clear_addr=0, front_bank=0, swap_pending=0, busy=0, rd_data=0, rd_valid=0.
  - A clear in progress is aborted and that bank is left partially cleared.
  - A pending swap is discarded.

## Timing
- Read latency is 1 cycle. rd_data and rd_valid update on the clock edge that samples rd_en.
- The read bank is the front_bank value in the rd_en cycle. A swap in that same cycle affects only subsequent reads.
- The write bank is the front_bank value in the wr_en cycle. A write coinciding with a swap lands in the old back bank, which becomes the new front.
- Reads and writes always target different banks, so there is no read-during-write hazard.
- Clear:
  - clear_req at cycle N: busy=1 from N+1 through N+2^ADDR_WIDTH.
  - busy=0 at N+2^ADDR_WIDTH+1.
  - With default parameters the clear takes 2048 cycles.
- Swap: front_bank and swap_pending change on the edge sampling a qualifying frame_end. The earliest swap is the cycle after swap_req.

## Test plan
- Reset, then swap: after reset, front_bank=0, busy=0, rd_valid=0.
  - Write 0x3 at addr 5, then rd_en at addr 5 → rd_data=0x0 from the front bank (uninitialised bank, cleared first via clear_req+swap setup).
  - swap_req, then frame_end → front_bank=1.
  - rd_en at addr 5 → rd_data=0x3 with rd_valid one cycle later.
- Pending across frames: swap_req at cycle 10, no frame_end for 100 cycles → swap_pending=1, front_bank unchanged.
  - frame_end at cycle 110 → front_bank toggles at 111 and swap_pending=0.
  - swap_req and frame_end together with pending=0 → pending=1, no toggle.
- Clear: fill the back bank with 0x2, pulse clear_req → busy high for exactly 2048 cycles.
  - wr_en during busy is ignored.
  - After a swap, reads of addrs 0, 1023 and 2047 all return 0x0.
- Swap blocked by clear: clear_req, then swap_req, then frame_end at clear cycle 500 → front_bank unchanged and swap_pending=1.
  - The next frame_end after busy falls → swap occurs.
- Reset mid-clear: reset at clear cycle 300 → busy=0, state IDLE, swap_pending=0, front_bank=0.
  - Addrs 0–299 read 0 and addr 300 keeps its prior value.
- Parametrisation: DATA_WIDTH=8, ADDR_WIDTH=4 → clear takes 16 cycles.
  - Write/read of 0xA5 at addr 15 round-trips across a swap.
  - clear_addr wraps to 0 with no stray write.
